rgb_to_yuv_encoder: RTL
=======================

# rgb_to_yuv_encoder

- Compression-side counterpart of the milestone-1 YUV→RGB decoder.
- Reads interleaved 24-bit RGB pixels from external SRAM, converts each pixel to YUV, and decimates U/V horizontally by 2.
- Writes Y, U′, V′ back to SRAM in exactly the packed layout the decoder consumes.
- Sits beside the decoder on the shared single-port SRAM bus; the top-level arbiter grants the bus to one block at a time.

## Interface
Parameters:
- IMG_WIDTH, 320, pixels per row (multiple of 4)
- IMG_HEIGHT, 240, rows
- Y_BASE, 18'd0, Y plane word base
- U_BASE, 18'd38400, U′ plane word base
- V_BASE, 18'd57600, V′ plane word base
- RGB_BASE, 18'd146944, RGB source word base

Ports:
- Clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin encoding; sampled only in IDLE
- SRAM_read_data  in  16  SRAM read data, valid 2 cycles after address issue
- SRAM_address  out  18  registered SRAM word address
- SRAM_write_data  out  16  registered write data
- SRAM_we_n  out  1  active-low write enable, registered
- done  out  1  high from end of last write until next accepted start

## Operation
- Byte packing matches the decoder: even sample in [7:0], odd sample in [15:8].
- RGB source words per pixel pair: word0 = {G0,R0}, word1 = {R1,B0}, word2 = {B1,G1}.
- Work unit is a group of 4 pixels, 19200 groups total, g = 0..19199; groups never straddle rows.
- Each group reads RGB_BASE+6g .. +6g+5.
- Each group writes Y words Y_BASE+2g, Y_BASE+2g+1, then U_BASE+g, then V_BASE+g.
- Conversion per pixel: 8-bit unsigned operands times signed coefficients, accumulated in ≥18-bit signed:
  - Y = 16 + ((66R + 129G + 25B + 128) >>> 8)
  - U = 128 + ((−38R − 74G + 112B + 128) >>> 8)
  - V = 128 + ((112R − 94G − 18B + 128) >>> 8)
- `>>>` is an arithmetic shift (floor). Each result is clipped to [0,255].
- Decimation: U′ = (U_even + U_odd + 1) >> 1, using the clipped values; V′ likewise.
- The U′ word for group g holds {U′(px 4g+2,4g+3), U′(px 4g,4g+1)}; V′ is identical.
- States:
  - IDLE: waits for start.
  - RD0..RD5: issue reads, we_n=1.
  - DR0, DR1: drain last read data.
  - CMP0, CMP1: finish MACs, clip, average.
  - WY0, WY1, WU, WV: writes, we_n=0.
  - After WV: next group's RD0, or DONE after group 19199.
  - DONE: returns to IDLE.
- start while not in IDLE is ignored. start in DONE/IDLE with done=1 clears done and restarts from g=0.

## Timing
- Reset values: SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1, done=0, state=IDLE, group counter=0, all datapath registers 0.
- start high in IDLE at cycle k → group cycle 0 is cycle k+1, with SRAM_address=RGB_BASE.
- Group period is exactly 14 cycles:
  - Reads issued at group cycles 0–5.
  - Read data captured at cycles 2–7.
  - Computation at cycles 8–9.
  - Writes at cycles 10 (Y even word), 11 (Y odd word), 12 (U′), 13 (V′).
- SRAM_we_n is low only in cycles 10–13; write address and data are valid in the same cycle.
- Full image: 19200 × 14 = 268800 cycles. done rises the cycle after the final V′ write, at k+268801.
- Group counter wraps to 0 only through IDLE; no writes are issued beyond V_BASE+19199.
- reset asserted mid-operation: next edge forces reset values, we_n=1 immediately, and no partial group completes.
- reset and start high on the same edge: reset wins.

## Test plan
- All-black RGB (0,0,0) → every Y word 0x1010, every U′/V′ word 0x8080; done at k+268801.
- All-white (255,255,255) → Y words 0xEBEB, U′/V′ words 0x8080.
- Pure red (255,0,0) → Y 0x5252, U′ 0x5A5A, V′ 0xF0F0; exercises negative-sum floor shift.
- Group 0 with px0 red, px1 black, px2/px3 black:
  - Y word0 = 0x1052.
  - U′ word = 0x806D, since (90+128+1)>>1 = 109.
  - V′ word = 0x80B8, since (240+128+1)>>1 = 184.
- Bus trace for group 0:
  - Addresses 146944..146949 at cycles k+1..k+6.
  - we_n low exactly at k+11..k+14, with addresses 0, 1, 38400, 57600.
  - Group 1 reads start at 146950.
- Reset at group 500 cycle 11 → we_n=1 next cycle, outputs at reset values. start re-pulsed during the run is ignored. A fresh start after reset re-encodes from g=0 correctly.

Source files
------------

// File: rtl/rgb_to_yuv_encoder_if.sv
// Shared single-port SRAM bus as seen by the RGB->YUV encoder.
// The encoder drives address, write data and write enable; memory returns read data.
interface rgb_to_yuv_encoder_if;
  logic [15:0] SRAM_read_data;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;

  modport master (
    input  SRAM_read_data,
    output SRAM_address,
    output SRAM_write_data,
    output SRAM_we_n
  );

  modport slave (
    output SRAM_read_data,
    input  SRAM_address,
    input  SRAM_write_data,
    input  SRAM_we_n
  );
endinterface

// File: rtl/rgb_to_yuv_encoder.sv
// RGB->YUV encoder: reads 4-pixel groups of packed RGB from SRAM and writes Y, U', V'
// (U/V decimated by 2) back in the decoder's layout, one group every 14 cycles.
//
// state | meaning
// IDLE  | waiting for start
// RD0-5 | issue the six RGB reads of the group
// DR0-1 | drain the last two reads
// CMP0  | per-pixel Y/U/V multiply-accumulate, shift and clip
// CMP1  | average U and V pairs
// WY0   | write Y word (pixels 0,1)
// WY1   | write Y word (pixels 2,3)
// WU    | write U' word
// WV    | write V' word, then next group or DONE
// DONE  | image finished, falls back to IDLE
module rgb_to_yuv_encoder #(
  parameter int          IMG_WIDTH  = 320,
  parameter int          IMG_HEIGHT = 240,
  parameter logic [17:0] Y_BASE     = 18'd0,
  parameter logic [17:0] U_BASE     = 18'd38400,
  parameter logic [17:0] V_BASE     = 18'd57600,
  parameter logic [17:0] RGB_BASE   = 18'd146944
) (
  input  logic                   Clock,
  input  logic                   reset,
  input  logic                   start,
  rgb_to_yuv_encoder_if.master   sram,
  output logic                   done
);

  localparam logic [17:0] LAST_GROUP = 18'(IMG_WIDTH * IMG_HEIGHT / 4 - 1);

  // Group states are consecutive so the in-group sequencer is just an increment.
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_RD0  = 4'd1;
  localparam logic [3:0] S_RD1  = 4'd2;
  localparam logic [3:0] S_RD2  = 4'd3;
  localparam logic [3:0] S_RD3  = 4'd4;
  localparam logic [3:0] S_RD4  = 4'd5;
  localparam logic [3:0] S_RD5  = 4'd6;
  localparam logic [3:0] S_DR0  = 4'd7;
  localparam logic [3:0] S_DR1  = 4'd8;
  localparam logic [3:0] S_CMP0 = 4'd9;
  localparam logic [3:0] S_CMP1 = 4'd10;
  localparam logic [3:0] S_WY0  = 4'd11;
  localparam logic [3:0] S_WY1  = 4'd12;
  localparam logic [3:0] S_WU   = 4'd13;
  localparam logic [3:0] S_WV   = 4'd14;
  localparam logic [3:0] S_DONE = 4'd15;

  logic [3:0]  state_q, state_d;
  logic [17:0] group_q, group_d;
  logic        done_q, done_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_n_q, we_n_d;

  logic [15:0] word_q [6];
  logic [15:0] word_d [6];
  logic [7:0]  y_q [4];
  logic [7:0]  y_d [4];
  logic [7:0]  u_q [4];
  logic [7:0]  u_d [4];
  logic [7:0]  v_q [4];
  logic [7:0]  v_d [4];
  logic [7:0]  up_q [2];
  logic [7:0]  up_d [2];
  logic [7:0]  vp_q [2];
  logic [7:0]  vp_d [2];

  logic [7:0]  px_r [4];
  logic [7:0]  px_g [4];
  logic [7:0]  px_b [4];

  function automatic logic [7:0] clip8(input logic signed [19:0] val);
    if (val < 20'sd0)
      return 8'd0;
    else if (val > 20'sd255)
      return 8'd255;
    else
      return val[7:0];
  endfunction

  function automatic logic [7:0] mac3(
    input logic [7:0]         r,
    input logic [7:0]         g,
    input logic [7:0]         b,
    input logic signed [19:0] cr,
    input logic signed [19:0] cg,
    input logic signed [19:0] cb,
    input logic signed [19:0] offset
  );
    logic signed [19:0] acc;
    acc = cr * $signed({12'd0, r}) + cg * $signed({12'd0, g})
        + cb * $signed({12'd0, b}) + 20'sd128;
    return clip8(offset + (acc >>> 8));
  endfunction

  function automatic logic [7:0] avg2(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b} + 9'd1;
    return sum[8:1];
  endfunction

  // Unpack the six captured words: {G0,R0}, {R1,B0}, {B1,G1} per pixel pair.
  always_comb begin
    px_r[0] = word_q[0][7:0];
    px_g[0] = word_q[0][15:8];
    px_b[0] = word_q[1][7:0];
    px_r[1] = word_q[1][15:8];
    px_g[1] = word_q[2][7:0];
    px_b[1] = word_q[2][15:8];
    px_r[2] = word_q[3][7:0];
    px_g[2] = word_q[3][15:8];
    px_b[2] = word_q[4][7:0];
    px_r[3] = word_q[4][15:8];
    px_g[3] = word_q[5][7:0];
    px_b[3] = word_q[5][15:8];
  end

  always_comb begin
    state_d = state_q;
    group_d = group_q;
    done_d  = done_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_n_d  = 1'b1;
    word_d  = word_q;
    y_d     = y_q;
    u_d     = u_q;
    v_d     = v_q;
    up_d    = up_q;
    vp_d    = vp_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RD0;
          group_d = 18'd0;
          done_d  = 1'b0;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_WV: begin
        if (group_q == LAST_GROUP) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_RD0;
          group_d = group_q + 18'd1;
        end
      end
      default: state_d = state_q + 4'd1;
    endcase

    // Read data lags its address by two cycles; shift it in so word[0] is the first read.
    if (state_q >= S_RD2 && state_q <= S_DR1) begin
      word_d[0] = word_q[1];
      word_d[1] = word_q[2];
      word_d[2] = word_q[3];
      word_d[3] = word_q[4];
      word_d[4] = word_q[5];
      word_d[5] = sram.SRAM_read_data;
    end

    if (state_q == S_CMP0) begin
      y_d[0] = mac3(px_r[0], px_g[0], px_b[0], 20'sd66, 20'sd129, 20'sd25, 20'sd16);
      y_d[1] = mac3(px_r[1], px_g[1], px_b[1], 20'sd66, 20'sd129, 20'sd25, 20'sd16);
      y_d[2] = mac3(px_r[2], px_g[2], px_b[2], 20'sd66, 20'sd129, 20'sd25, 20'sd16);
      y_d[3] = mac3(px_r[3], px_g[3], px_b[3], 20'sd66, 20'sd129, 20'sd25, 20'sd16);
      u_d[0] = mac3(px_r[0], px_g[0], px_b[0], -20'sd38, -20'sd74, 20'sd112, 20'sd128);
      u_d[1] = mac3(px_r[1], px_g[1], px_b[1], -20'sd38, -20'sd74, 20'sd112, 20'sd128);
      u_d[2] = mac3(px_r[2], px_g[2], px_b[2], -20'sd38, -20'sd74, 20'sd112, 20'sd128);
      u_d[3] = mac3(px_r[3], px_g[3], px_b[3], -20'sd38, -20'sd74, 20'sd112, 20'sd128);
      v_d[0] = mac3(px_r[0], px_g[0], px_b[0], 20'sd112, -20'sd94, -20'sd18, 20'sd128);
      v_d[1] = mac3(px_r[1], px_g[1], px_b[1], 20'sd112, -20'sd94, -20'sd18, 20'sd128);
      v_d[2] = mac3(px_r[2], px_g[2], px_b[2], 20'sd112, -20'sd94, -20'sd18, 20'sd128);
      v_d[3] = mac3(px_r[3], px_g[3], px_b[3], 20'sd112, -20'sd94, -20'sd18, 20'sd128);
    end

    if (state_q == S_CMP1) begin
      up_d[0] = avg2(u_q[0], u_q[1]);
      up_d[1] = avg2(u_q[2], u_q[3]);
      vp_d[0] = avg2(v_q[0], v_q[1]);
      vp_d[1] = avg2(v_q[2], v_q[3]);
    end

    // Bus outputs are registered, so they are set up from the state being entered.
    case (state_d)
      S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_RD5:
        addr_d = RGB_BASE + group_d * 18'd6 + {14'd0, state_d - S_RD0};
      S_WY0: begin
        addr_d  = Y_BASE + {group_d[16:0], 1'b0};
        wdata_d = {y_q[1], y_q[0]};
        we_n_d  = 1'b0;
      end
      S_WY1: begin
        addr_d  = Y_BASE + {group_d[16:0], 1'b1};
        wdata_d = {y_q[3], y_q[2]};
        we_n_d  = 1'b0;
      end
      S_WU: begin
        addr_d  = U_BASE + group_d;
        wdata_d = {up_q[1], up_q[0]};
        we_n_d  = 1'b0;
      end
      S_WV: begin
        addr_d  = V_BASE + group_d;
        wdata_d = {vp_q[1], vp_q[0]};
        we_n_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      group_q <= 18'd0;
      done_q  <= 1'b0;
      addr_q  <= 18'd0;
      wdata_q <= 16'd0;
      we_n_q  <= 1'b1;
      word_q  <= '{default: '0};
      y_q     <= '{default: '0};
      u_q     <= '{default: '0};
      v_q     <= '{default: '0};
      up_q    <= '{default: '0};
      vp_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      group_q <= group_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_n_q  <= we_n_d;
      word_q  <= word_d;
      y_q     <= y_d;
      u_q     <= u_d;
      v_q     <= v_d;
      up_q    <= up_d;
      vp_q    <= vp_d;
    end
  end

  assign sram.SRAM_address    = addr_q;
  assign sram.SRAM_write_data = wdata_q;
  assign sram.SRAM_we_n       = we_n_q;
  assign done                 = done_q;

endmodule
